// File: rtl/ula_defs.sv
// ula_defs: shared definitions for the multicycle ALU and its bench.
// Holds the 4-bit operation codes, the controller state encoding and a
// helper that tells which operations use the iterative MUL/DIV unit.
package ula_defs;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_NOR = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// ula_muldiv_iter: one-bit-per-cycle unsigned multiplier (shift-add) and
// restoring divider sharing a single 2*WIDTH working register.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        load operands and begin (one-cycle pulse)
//   op_div       1 = divide, 0 = multiply (latched on start)
//   a, b         operands (latched on start)
//   last         high during the final iteration cycle
//   result       value the working register takes at the end of this cycle;
//                on the last cycle it is the final {high, low} result
module ula_muldiv_iter
    import ula_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);

    logic                active;
    logic                div_q;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH-1:0]  work;
    logic [WIDTH-1:0]    divisor;

    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_shift;
    logic [WIDTH:0]      div_try;

    // work = {high, low}. MUL: high accumulates partial product, low holds
    // the remaining multiplier bits. DIV: high is the partial remainder, low
    // the dividend bits being shifted out / quotient bits shifted in.
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, divisor} : '0);
        div_shift = work[2*WIDTH-1:WIDTH-1];
        div_try   = div_shift - {1'b0, divisor};
        if (div_q) begin
            // Comparison instead of borrow bit keeps B=0 well defined:
            // every step subtracts, so quotient = all ones, remainder = A.
            if (div_shift >= {1'b0, divisor})
                result = {div_try[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            else
                result = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        end else begin
            result = {mul_sum, work[WIDTH-1:1]};
        end
    end

    assign last = active && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            div_q   <= 1'b0;
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
        end else if (start) begin
            active  <= 1'b1;
            div_q   <= op_div;
            cnt     <= '0;
            work    <= {{WIDTH{1'b0}}, a};
            divisor <= b;
        end else if (active) begin
            work <= result;
            if (last) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multicycle ALU. Logic, shift, add/sub and SLT complete in
// one cycle; MUL and DIV run WIDTH iterations in ula_muldiv_iter.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start, ALUctl, A, B    request, opcode and operands (taken in IDLE only)
//   ALUOut                 registered result {high/remainder, low/quotient}
//   Zero, Carry, Overflow, Err   registered flags, valid with done
//   busy                   controller not in IDLE
//   done                   one-cycle completion pulse
//   state_dbg              current controller state
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// controller is IDLE (busy=0). Start is ignored in every other state, so a
// held start launches the next operation on the first IDLE cycle after done.
// ALUOut and flags update on the edge that makes done high and hold until
// the next done.
module ula_multiciclo
    import ula_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           ALUctl,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   ALUOut,
    output logic                 Zero,
    output logic                 Carry,
    output logic                 Overflow,
    output logic                 Err,
    output logic                 busy,
    output logic                 done,
    output state_t               state_dbg
);

    localparam int SW = $clog2(WIDTH);

    state_t state, next_state;
    logic   accept;
    logic   iter_op;
    logic   iter_last;
    logic   div_zero_q;
    logic [2*WIDTH-1:0] iter_result;

    logic [WIDTH:0]      add_sum;
    logic [WIDTH:0]      sub_diff;
    logic [2*WIDTH-1:0]  single_res;
    logic                single_carry;
    logic                single_ovf;
    logic                single_err;

    assign iter_op  = is_iter_op(ALUctl);
    assign add_sum  = {1'b0, A} + {1'b0, B};
    assign sub_diff = {1'b0, A} - {1'b0, B};

    // Single-cycle datapath, evaluated from the live inputs on the accept edge.
    always_comb begin
        single_res   = '0;
        single_carry = 1'b0;
        single_ovf   = 1'b0;
        single_err   = 1'b0;
        case (ALUctl)
            OP_AND: single_res[WIDTH-1:0] = A & B;
            OP_OR:  single_res[WIDTH-1:0] = A | B;
            OP_XOR: single_res[WIDTH-1:0] = A ^ B;
            OP_NOR: single_res[WIDTH-1:0] = ~(A | B);
            OP_SLL: single_res[WIDTH-1:0] = A << B[SW-1:0];
            OP_SRL: single_res[WIDTH-1:0] = A >> B[SW-1:0];
            OP_SLT: single_res[0] = $signed(A) < $signed(B);
            OP_ADD: begin
                single_res[WIDTH:0] = add_sum;
                single_carry        = add_sum[WIDTH];
                single_ovf          = (A[WIDTH-1] == B[WIDTH-1]) &&
                                      (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // sub_diff[WIDTH] is the borrow: 1 when A < B unsigned.
                single_res[WIDTH:0] = sub_diff;
                single_carry        = sub_diff[WIDTH];
                single_ovf          = (A[WIDTH-1] != B[WIDTH-1]) &&
                                      (sub_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL, OP_DIV: begin
                // produced by the iterative unit
            end
            default: single_err = 1'b1;
        endcase
    end

    // Controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = iter_op ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: if (iter_last) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    ula_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && iter_op),
        .op_div (ALUctl == OP_DIV),
        .a      (A),
        .b      (B),
        .last   (iter_last),
        .result (iter_result)
    );

    // Result and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUOut     <= '0;
            Zero       <= 1'b1;
            Carry      <= 1'b0;
            Overflow   <= 1'b0;
            Err        <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept && !iter_op) begin
            ALUOut   <= single_res;
            Zero     <= (single_res == '0);
            Carry    <= single_carry;
            Overflow <= single_ovf;
            Err      <= single_err;
        end else if (accept) begin
            div_zero_q <= (ALUctl == OP_DIV) && (B == '0);
        end else if ((state == S_EXEC) && iter_last) begin
            ALUOut   <= iter_result;
            Zero     <= (iter_result == '0);
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Err      <= div_zero_q;
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed and randomized checks of ula_multiciclo
// (WIDTH=8) against an arithmetic reference model.
module tb_ula_multiciclo;
    import ula_defs::*;

    localparam int W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [3:0]        ALUctl;
    logic [W-1:0]      A;
    logic [W-1:0]      B;
    logic [2*W-1:0]    ALUOut;
    logic              Zero, Carry, Overflow, Err, busy, done;
    state_t            state_dbg;

    int errors = 0;
    int checks = 0;

    ula_multiciclo #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ALUctl    (ALUctl),
        .A         (A),
        .B         (B),
        .ALUOut    (ALUOut),
        .Zero      (Zero),
        .Carry     (Carry),
        .Overflow  (Overflow),
        .Err       (Err),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [2*W-1:0] out,
                                  output logic z, output logic c, output logic o,
                                  output logic e);
        longint ua, ub, sa, sb, r, mask, smax, smin;
        int sh;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        mask = (64'd1 << W) - 1;
        smax = (64'd1 << (W - 1)) - 1;
        smin = -(64'd1 << (W - 1));
        sh   = int'(ub % W);
        c = 1'b0; o = 1'b0; e = 1'b0; r = 0;
        case (op)
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_NOR: r = (~(ua | ub)) & mask;
            OP_SLL: r = (ua << sh) & mask;
            OP_SRL: r = ua >> sh;
            OP_SLT: r = (sa < sb) ? 1 : 0;
            OP_ADD: begin
                r = ua + ub;
                c = (ua + ub) > mask;
                o = ((sa + sb) > smax) || ((sa + sb) < smin);
            end
            OP_SUB: begin
                c = ua < ub;
                r = ((ua - ub) & mask) | (c ? (64'd1 << W) : 0);
                o = ((sa - sb) > smax) || ((sa - sb) < smin);
            end
            OP_MUL: r = ua * ub;
            OP_DIV: begin
                if (ub == 0) begin
                    e = 1'b1;
                    r = (ua << W) | mask;
                end else begin
                    r = ((ua % ub) << W) | (ua / ub);
                end
            end
            default: begin
                r = 0;
                e = 1'b1;
            end
        endcase
        out = r[2*W-1:0];
        z   = (r == 0);
    endfunction

    // ---------------- driver ----------------
    // Issues one operation and follows it to completion. poke (0 = none) is
    // the cycle at which a stray start with another opcode is raised for one
    // cycle while the operation is in progress.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke);
        logic [2*W-1:0] e_out;
        logic e_z, e_c, e_o, e_e;
        int exp_lat, lat, busy_cnt;
        bit seen;
        string t;
        model(op, a, b, e_out, e_z, e_c, e_o, e_e);
        exp_lat = is_iter_op(op) ? W + 1 : 1;
        t = $sformatf("op%0d a=%0h b=%0h", op, a, b);

        @(negedge clk);
        start = 1'b1; ALUctl = op; A = a; B = b;
        @(posedge clk);
        #1;
        // operands are scrambled right after the start edge
        start = 1'b0; ALUctl = 4'($urandom); A = W'($urandom); B = W'($urandom);
        lat = 0; busy_cnt = 0; seen = 1'b0;
        for (int c = 1; c <= 3 * W; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_cnt++;
            if (c == poke + 1 && poke != 0) start = 1'b0;
            if (done) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
            if (c == poke) begin
                start = 1'b1; ALUctl = OP_AND;
            end
        end
        start = 1'b0;
        check({t, " done_seen"}, 64'(seen), 64'd1);
        check({t, " latency"}, 64'(lat), 64'(exp_lat));
        check({t, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check({t, " state_done"}, 64'(state_dbg), 64'(S_DONE));
        check({t, " ALUOut"}, 64'(ALUOut), 64'(e_out));
        check({t, " Zero"}, 64'(Zero), 64'(e_z));
        check({t, " Carry"}, 64'(Carry), 64'(e_c));
        check({t, " Overflow"}, 64'(Overflow), 64'(e_o));
        check({t, " Err"}, 64'(Err), 64'(e_e));
        @(posedge clk);
        #1;
        check({t, " done_pulse_end"}, 64'(done), 64'd0);
        check({t, " idle_after"}, 64'(busy), 64'd0);
        check({t, " ALUOut_hold"}, 64'(ALUOut), 64'(e_out));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit saw_done;
        logic [3:0] rop;

        rst = 1'b1; start = 1'b0; ALUctl = '0; A = '0; B = '0;
        #1;
        check("reset ALUOut", 64'(ALUOut), 64'd0);
        check("reset Zero", 64'(Zero), 64'd1);
        check("reset Carry", 64'(Carry), 64'd0);
        check("reset Overflow", 64'(Overflow), 64'd0);
        check("reset Err", 64'(Err), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset state", 64'(state_dbg), 64'(S_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // directed cases
        run_op(OP_ADD, 8'hFF, 8'h01, 0);
        run_op(OP_SUB, 8'h80, 8'h01, 0);
        run_op(OP_SUB, 8'h05, 8'h05, 0);
        run_op(OP_SUB, 8'h03, 8'h09, 0);
        run_op(OP_ADD, 8'h7F, 8'h01, 0);
        run_op(OP_MUL, 8'hFF, 8'hFF, 0);
        run_op(OP_DIV, 8'd100, 8'd7, 0);
        run_op(OP_DIV, 8'h2A, 8'h00, 0);
        run_op(4'd15, 8'h5A, 8'hA5, 0);
        run_op(OP_SLT, 8'hFF, 8'h01, 0);
        run_op(OP_SLT, 8'h01, 8'hFF, 0);
        run_op(OP_SLL, 8'h81, 8'h0B, 0);
        run_op(OP_SRL, 8'h81, 8'h07, 0);
        run_op(OP_NOR, 8'h0F, 8'h30, 0);
        run_op(OP_MUL, 8'hFF, 8'hFF, 3);
        run_op(OP_MUL, 8'h00, 8'h37, 0);

        // start held high through DONE: ignored in DONE, taken in next IDLE
        @(negedge clk);
        start = 1'b1; ALUctl = OP_ADD; A = 8'd1; B = 8'd2;
        @(posedge clk);
        #1;
        check("held first done", 64'(done), 64'd1);
        check("held first ALUOut", 64'(ALUOut), 64'd3);
        A = 8'd3; B = 8'd4;
        @(posedge clk);
        #1;
        check("held in_done ignored", 64'(busy), 64'd0);
        check("held ALUOut kept", 64'(ALUOut), 64'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held second done", 64'(done), 64'd1);
        check("held second ALUOut", 64'(ALUOut), 64'd7);
        @(posedge clk);
        #1;

        // reset in the middle of a MUL aborts with no done pulse
        @(negedge clk);
        start = 1'b1; ALUctl = OP_MUL; A = 8'hFF; B = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; ALUctl = OP_AND;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort busy before rst", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort ALUOut", 64'(ALUOut), 64'd0);
        check("abort Zero", 64'(Zero), 64'd1);
        check("abort Err", 64'(Err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (3 * W) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort no done", 64'(saw_done), 64'd0);
        run_op(OP_MUL, 8'd3, 8'd5, 0);

        // randomized operations over the full opcode space
        repeat (60) begin
            rop = 4'($urandom_range(0, 15));
            run_op(rop, W'($urandom), ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
                   is_iter_op(rop) && ($urandom_range(0, 1) == 1) ? $urandom_range(2, W - 1) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
